vx_stream_rsp_xbar: RTL



---
 rtl/vx_stream_rsp_xbar.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/vx_stream_rsp_xbar.sv
`default_nettype none
//==============================================================================
// Module : vx_stream_rsp_xbar
// Response-return crossbar: per-requester round-robin arbitration, optional
// 2-entry output buffer, wrap-around collision counter.
// Rev    : 1.0
//==============================================================================
module vx_stream_rsp_xbar #(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_OUTPUTS   = 4,
    parameter int DATAW         = 32,
    parameter int IN_WIDTH      = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1,
    parameter int OUT_WIDTH     = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
    parameter int OUT_BUF       = 1,
    parameter int PERF_CTR_BITS = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS-1:0]                 valid_in,
    input  logic [NUM_INPUTS-1:0][DATAW-1:0]      data_in,
    input  logic [NUM_INPUTS-1:0][OUT_WIDTH-1:0]  sel_in,
    output logic [NUM_INPUTS-1:0]                 ready_in,
    output logic [NUM_OUTPUTS-1:0]                valid_out,
    output logic [NUM_OUTPUTS-1:0][DATAW-1:0]     data_out,
    output logic [NUM_OUTPUTS-1:0][IN_WIDTH-1:0]  sel_out,
    input  logic [NUM_OUTPUTS-1:0]                ready_out,
    output logic [PERF_CTR_BITS-1:0]              collisions
);

    localparam logic [IN_WIDTH-1:0] c_LAST_RST = IN_WIDTH'(NUM_INPUTS - 1);

    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] w_cand;
    logic [NUM_OUTPUTS-1:0]                 w_gnt_valid;
    logic [NUM_OUTPUTS-1:0][IN_WIDTH-1:0]   w_gnt_idx;
    logic [NUM_OUTPUTS-1:0][DATAW-1:0]      w_gnt_data;
    logic [NUM_OUTPUTS-1:0]                 w_arb_ready;
    logic [NUM_OUTPUTS-1:0]                 w_fire;
    logic [NUM_OUTPUTS-1:0][IN_WIDTH-1:0]   r_last;
    logic [NUM_INPUTS-1:0]                  w_ready_in;
    logic [NUM_INPUTS-1:0]                  w_coll;
    logic [NUM_INPUTS-1:0]                  r_coll;
    logic [PERF_CTR_BITS-1:0]               w_coll_cnt;
    logic [PERF_CTR_BITS-1:0]               r_collisions;

    // Out-of-range destinations never match any output, so they are never candidates.
    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                w_cand[o][i] = valid_in[i] && ((NUM_OUTPUTS == 1) || (int'(sel_in[i]) == o));
            end
        end
    end

    // Scan from farthest to nearest so the candidate right after last wins.
    always_comb begin
        int w_idx;
        w_idx = 0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            w_gnt_valid[o] = 1'b0;
            w_gnt_idx[o]   = '0;
            w_gnt_data[o]  = '0;
            for (int k = NUM_INPUTS; k >= 1; k--) begin
                w_idx = (int'(r_last[o]) + k) % NUM_INPUTS;
                if (w_cand[o][w_idx]) begin
                    w_gnt_valid[o] = 1'b1;
                    w_gnt_idx[o]   = IN_WIDTH'(w_idx);
                end
            end
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (int'(w_gnt_idx[o]) == i) begin
                    w_gnt_data[o] = data_in[i];
                end
            end
        end
    end

    assign w_fire = w_gnt_valid & w_arb_ready;

    always_ff @(posedge clk) begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (reset) begin
                r_last[o] <= c_LAST_RST;
            end else if (w_fire[o]) begin
                r_last[o] <= w_gnt_idx[o];
            end
        end
    end

    // A source collides when its arbiter moved data but picked someone else.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_ready_in[i] = 1'b0;
            w_coll[i]     = 1'b0;
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                if (w_fire[o] && (int'(w_gnt_idx[o]) == i)) begin
                    w_ready_in[i] = 1'b1;
                end
                if (w_fire[o] && w_cand[o][i]) begin
                    w_coll[i] = 1'b1;
                end
            end
            w_coll[i] = w_coll[i] && !w_ready_in[i];
        end
    end

    assign ready_in = w_ready_in;

    always_comb begin
        w_coll_cnt = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_coll_cnt = w_coll_cnt + PERF_CTR_BITS'(r_coll[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coll       <= '0;
            r_collisions <= '0;
        end else begin
            r_coll       <= w_coll;
            r_collisions <= r_collisions + w_coll_cnt;
        end
    end

    assign collisions = r_collisions;

    generate
        if (OUT_BUF != 0) begin : g_buf
            for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_fifo
                logic [1:0]          r_count;
                logic                r_full;
                logic [DATAW-1:0]    r_head_data;
                logic [DATAW-1:0]    r_tail_data;
                logic [IN_WIDTH-1:0] r_head_sel;
                logic [IN_WIDTH-1:0] r_tail_sel;
                logic                w_push;
                logic                w_pop;
                logic [1:0]          w_count_n;

                assign w_push         = w_fire[o];
                assign w_pop          = (r_count != 2'd0) && ready_out[o];
                assign w_count_n      = r_count + 2'(w_push) - 2'(w_pop);
                assign w_arb_ready[o] = !r_full && !reset;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_count <= 2'd0;
                        r_full  <= 1'b0;
                    end else begin
                        r_count <= w_count_n;
                        r_full  <= (w_count_n == 2'd2);
                        if (w_pop && (r_count == 2'd2)) begin
                            r_head_data <= r_tail_data;
                            r_head_sel  <= r_tail_sel;
                        end else if (w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
                            r_head_data <= w_gnt_data[o];
                            r_head_sel  <= w_gnt_idx[o];
                        end
                        if (w_push && (((r_count == 2'd1) && !w_pop) || (r_count == 2'd2))) begin
                            r_tail_data <= w_gnt_data[o];
                            r_tail_sel  <= w_gnt_idx[o];
                        end
                    end
                end

                assign valid_out[o] = (r_count != 2'd0);
                assign data_out[o]  = r_head_data;
                assign sel_out[o]   = r_head_sel;
            end
        end else begin : g_nobuf
            for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_wire
                assign w_arb_ready[o] = ready_out[o] && !reset;
                assign valid_out[o]   = w_gnt_valid[o] && !reset;
                assign data_out[o]    = w_gnt_data[o];
                assign sel_out[o]     = w_gnt_idx[o];
            end
        end
    endgenerate

    // Destinations beyond the last requester are a source protocol error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                assert ((NUM_OUTPUTS == 1) || !valid_in[i] || (int'(sel_in[i]) < NUM_OUTPUTS));
            end
        end
    end

endmodule
`default_nettype wire
